fifo_drain_reader: RTL and testbench

- Consumer-side engine for the project FIFO. It drives `fifo_rd` from `fifo_empty`/`almost_empty`, captures the registered `fifo_data_out` after a fixed read latency, and presents words to a downstream stage over a valid/ready handshake.
- A small skid buffer absorbs in-flight words, so downstream back-pressure never drops data and never over-reads the FIFO.

---
 rtl/fifo_drain_reader_pkg.sv | 18 +
 rtl/fifo_drain_reader_skid_buffer.sv | 85 ++++++++
 rtl/fifo_drain_reader.sv | 128 ++++++++++++
 tb/tb_fifo_drain_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_reader_pkg.sv
// Shared definitions for the FIFO drain reader: FSM state encodings and
// parameter defaults shared with the project FIFO.
package fifo_drain_reader_pkg;

  localparam int unsigned FIFO_WORD_SIZE = 6;
  localparam int unsigned FIFO_PTR_L     = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    BACKOFF = 2'd2
  } drain_state_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_drain_reader_skid_buffer.sv
// Circular skid buffer with occupancy tracking; the head word is held in a
// register so data_out is stable while the downstream stage stalls.
module fifo_drain_reader_skid_buffer
  import fifo_drain_reader_pkg::*;
#(
  parameter int unsigned WORD_SIZE = FIFO_WORD_SIZE,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_L     = 3
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 wr_en,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 ready_in,
  output logic [CNT_L-1:0]     occ,
  output logic [WORD_SIZE-1:0] head,
  output logic                 valid
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);

  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic [WORD_SIZE-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_L-1:0]     occ_q, occ_d;
  logic [WORD_SIZE-1:0] head_q, head_d;
  logic                 pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid = (occ_q != '0);
  assign pop   = valid && ready_in;
  assign occ   = occ_q;
  assign head  = head_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({wr_en, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    // Reading the post-write image lets a word written into an empty slot
    // appear at the head in the same cycle it becomes valid.
    head_d = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      head_q   <= head_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_L && wr_en && (occ_q == CNT_L'(DEPTH))) begin
      $display("fifo_drain_reader_skid_buffer: capture into full buffer at %0t", $time);
    end
  end
`endif

endmodule

// File: rtl/fifo_drain_reader.sv
// Consumer-side FIFO drain engine: credit-limited reads, fixed read latency
// capture into a skid buffer, valid/ready output. Optional: FIFO_DRAIN_STATS_EN.
module fifo_drain_reader
  import fifo_drain_reader_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = FIFO_WORD_SIZE,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned SKID_DEPTH = 4,
  parameter int unsigned CNT_L      = 3
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic                 almost_empty,
  input  logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 fifo_rd,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 busy,
  output logic [15:0]          rd_word_count
);

  localparam logic [CNT_L:0] DEPTH_C = (CNT_L + 1)'(SKID_DEPTH);

  drain_state_t          state_q, state_d;
  logic [CNT_L-1:0]      gap_q, gap_d;
  logic [RD_LATENCY-1:0] shift_q, shift_d;
  logic [CNT_L-1:0]      inflight;
  logic [CNT_L-1:0]      occ;
  logic [CNT_L:0]        credit_sum;
  logic                  credit_ok;
  logic                  capture;

  assign capture = shift_q[RD_LATENCY-1];

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_L'(shift_q[i]);
    end
    // Registered occupancy: a same-cycle downstream pop frees its credit next cycle.
    credit_sum = {1'b0, inflight} + {1'b0, occ};
    credit_ok  = (credit_sum < DEPTH_C);
    // Truncating cast drops the oldest bit, which also covers RD_LATENCY == 1.
    shift_d    = RD_LATENCY'({shift_q, fifo_rd});
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    fifo_rd = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        fifo_rd = enable && !fifo_empty && credit_ok;
        if (fifo_rd && almost_empty) begin
          state_d = BACKOFF;
          gap_d   = CNT_L'(RD_LATENCY);
        end else if (!enable || fifo_empty) begin
          state_d = IDLE;
        end
      end
      BACKOFF: begin
        gap_d = gap_q - 1'b1;
        if (gap_d == '0) begin
          state_d = enable ? ACTIVE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      gap_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
    end
  end

  fifo_drain_reader_skid_buffer #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH     (SKID_DEPTH),
    .CNT_L     (CNT_L)
  ) u_skid (
    .clk      (clk),
    .reset_L  (reset_L),
    .wr_en    (capture),
    .wr_data  (fifo_data_out),
    .ready_in (ready_in),
    .occ      (occ),
    .head     (data_out),
    .valid    (valid_out)
  );

  assign busy = (shift_q != '0) || (occ != '0);

`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q + 16'(valid_out && ready_in);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign rd_word_count = word_cnt_q;
`else
  assign rd_word_count = '0;
`endif

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Directed self-checking bench for fifo_drain_reader with a behavioural
// FIFO model (two-cycle registered read path).
module tb_fifo_drain_reader;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        enable;
  logic        fifo_empty;
  logic        almost_empty;
  logic [5:0]  fifo_data_out;
  logic        fifo_rd;
  logic [5:0]  data_out;
  logic        valid_out;
  logic        ready_in;
  logic        busy;
  logic [15:0] rd_word_count;

  always #5 clk = ~clk;

  fifo_drain_reader #(
    .WORD_SIZE  (6),
    .RD_LATENCY (2),
    .SKID_DEPTH (4),
    .CNT_L      (3)
  ) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .almost_empty  (almost_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd       (fifo_rd),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .busy          (busy),
    .rd_word_count (rd_word_count)
  );

  logic [5:0] fq[$];
  logic [5:0] stage;
  int         ae_lvl;
  int         cyc;
  int         nrd;
  int         overread;
  logic [5:0] dq[$];
  int         rd_cyc[$];
  int         vld_cyc[$];
  int         dl_cyc[$];
  int         total = 0;
  int         bad = 0;

  task automatic upd_flags();
    fifo_empty   = (fq.size() == 0);
    almost_empty = (fq.size() <= ae_lvl);
  endtask

  task automatic clear_logs();
    nrd = 0;
    overread = 0;
    dq.delete();
    rd_cyc.delete();
    vld_cyc.delete();
    dl_cyc.delete();
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(6'(first + i));
    upd_flags();
  endtask

  // One clock: sample DUT at negedge, then update FIFO model just after posedge.
  task automatic tick();
    logic       rd, v, acc;
    logic [5:0] d;
    @(negedge clk);
    rd  = fifo_rd;
    v   = valid_out;
    acc = valid_out && ready_in;
    d   = data_out;
    @(posedge clk);
    #1;
    if (rd) begin nrd++; rd_cyc.push_back(cyc); end
    if (v) vld_cyc.push_back(cyc);
    if (acc) begin dq.push_back(d); dl_cyc.push_back(cyc); end
    fifo_data_out = stage;
    if (rd) begin
      if (fq.size() > 0) stage = fq.pop_front();
      else overread++;
    end
    upd_flags();
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000;
  endfunction

  function automatic logic [5:0] word_at(input int i);
    if (i < dq.size()) return dq[i];
    return 6'bx;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0;
    enable = 1'b0;
    ready_in = 1'b0;
    fifo_data_out = '0;
    stage = '0;
    ae_lvl = 0;
    cyc = 0;
    clear_logs();
    upd_flags();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", rd_word_count, 0);
    reset_L = 1'b1;
    tick();
    tick();

    // Stream 0x01..0x04 with ready high
    clear_logs();
    load(1, 4);
    enable = 1'b1;
    ready_in = 1'b1;
    repeat (12) tick();
    chk("stream_nrd", nrd, 4);
    chk("stream_words", dq.size(), 4);
    for (int i = 0; i < 4; i++) chk("stream_word", word_at(i), i + 1);
    chk("stream_latency", at(vld_cyc, 0) - at(rd_cyc, 0), 3);
    chk("stream_gapless", at(dl_cyc, 3) - at(dl_cyc, 0), 3);
    chk("stream_busy_end", busy, 0);
    chk("stream_overread", overread, 0);

    // Async reset with two reads in flight
    clear_logs();
    load(16, 4);
    for (int i = 0; i < 10 && nrd < 2; i++) tick();
    chk("rstmid_two_reads", nrd, 2);
    chk("rstmid_busy_before", busy, 1);
    #2;
    reset_L = 1'b0;
    enable = 1'b0;
    #1;
    chk("rstmid_fifo_rd", fifo_rd, 0);
    chk("rstmid_valid", valid_out, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_data", data_out, 0);
    tick();
    reset_L = 1'b1;
    repeat (6) tick();
    chk("rstmid_no_stale_valid", vld_cyc.size(), 0);
    chk("rstmid_busy_after", busy, 0);
    chk("rstmid_no_reads", nrd, 2);
    fq.delete();
    upd_flags();

    // Back-pressure: 8 words queued, ready low
    clear_logs();
    load(1, 8);
    ready_in = 1'b0;
    enable = 1'b1;
    repeat (15) tick();
    chk("bp_nrd_capped", nrd, 4);
    chk("bp_valid", valid_out, 1);
    chk("bp_head", data_out, 1);
    repeat (3) tick();
    chk("bp_hold_head", data_out, 1);
    chk("bp_hold_valid", valid_out, 1);
    chk("bp_nrd_still", nrd, 4);
    ready_in = 1'b1;
    repeat (20) tick();
    chk("bp_nrd_total", nrd, 8);
    chk("bp_words", dq.size(), 8);
    for (int i = 0; i < 8; i++) chk("bp_word", word_at(i), i + 1);
    chk("bp_busy_end", busy, 0);
    chk("bp_overread", overread, 0);

    // Near empty: back-off spacing between reads
    clear_logs();
    ae_lvl = 2;
    load(17, 2);
    repeat (14) tick();
    chk("ae_nrd", nrd, 2);
    chk("ae_spacing", at(rd_cyc, 1) - at(rd_cyc, 0), 3);
    chk("ae_words", dq.size(), 2);
    chk("ae_word0", word_at(0), 17);
    chk("ae_word1", word_at(1), 18);
    chk("ae_overread", overread, 0);
    ae_lvl = 0;
    upd_flags();

    // Drop enable after three of six reads
    clear_logs();
    load(33, 6);
    for (int i = 0; i < 20 && nrd < 3; i++) tick();
    enable = 1'b0;
    chk("en_busy_after_drop", busy, 1);
    repeat (10) tick();
    chk("en_nrd", nrd, 3);
    chk("en_words", dq.size(), 3);
    for (int i = 0; i < 3; i++) chk("en_word", word_at(i), 33 + i);
    chk("en_busy_end", busy, 0);
    chk("en_fifo_rd_end", fifo_rd, 0);
    fq.delete();
    upd_flags();

    // Delivered-word counter over 10 handshakes
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    clear_logs();
    load(1, 10);
    enable = 1'b1;
    ready_in = 1'b1;
    repeat (25) tick();
    chk("stats_words", dq.size(), 10);
`ifdef FIFO_DRAIN_STATS_EN
    chk("stats_count", rd_word_count, 10);
`else
    chk("stats_count", rd_word_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
